// File: rtl/alu_issue_unit.sv
// Issue/collect wrapper for an external add/sub ALU: decodes RV32I ALU, load/store and BEQ/BNE ops.
// Optional ALU_ILLEGAL_TRAP_EN adds an 'illegal' output and squashes unsupported ops.
module alu_issue_unit #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  input  logic [N-1:0] rs1_val,
  input  logic [N-1:0] rs2_val,
  input  logic [N-1:0] imm,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
`ifdef ALU_ILLEGAL_TRAP_EN
  output logic         illegal,
`endif
  output logic         taken
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;
  typedef enum logic [1:0] {BrNone, BrEq, BrNe} br_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, b_q, dec_a, dec_b;
  logic           sub_q, dec_sub;
  br_e            br_q, dec_br;
  logic [N-1:0]   result_q, result_d;
  logic           zero_q, zero_d, taken_q, taken_d;
  logic           accept;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic           dec_ill, ill_q, illegal_q;
`endif

  // Anything not matched below falls through as add of rs1/rs2.
  always_comb begin
    dec_a   = rs1_val;
    dec_b   = rs2_val;
    dec_sub = 1'b0;
    dec_br  = BrNone;
`ifdef ALU_ILLEGAL_TRAP_EN
    dec_ill = 1'b1;
`endif
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000) begin
          dec_sub = funct7b5;
`ifdef ALU_ILLEGAL_TRAP_EN
          dec_ill = 1'b0;
`endif
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          dec_b = imm;
`ifdef ALU_ILLEGAL_TRAP_EN
          dec_ill = 1'b0;
`endif
        end
      end
      7'b0000011, 7'b0100011: begin
        dec_b = imm;
`ifdef ALU_ILLEGAL_TRAP_EN
        dec_ill = 1'b0;
`endif
      end
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_sub = 1'b1;
          dec_br  = (funct3 == 3'b000) ? BrEq : BrNe;
`ifdef ALU_ILLEGAL_TRAP_EN
          dec_ill = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 2'b00;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StIssue;
      end
      StIssue: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_ctrl = {1'b0, sub_q};
        state_d  = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = (state_q == StIdle) && in_valid;

  always_comb begin
    result_d = alu_result;
    zero_d   = alu_zero;
    case (br_q)
      BrEq:    taken_d = alu_zero;
      BrNe:    taken_d = !alu_zero;
      default: taken_d = 1'b0;
    endcase
`ifdef ALU_ILLEGAL_TRAP_EN
    if (ill_q) begin
      result_d = '0;
      zero_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      br_q     <= BrNone;
      result_q <= '0;
      zero_q   <= 1'b0;
      taken_q  <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
      ill_q     <= 1'b0;
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= dec_a;
        b_q   <= dec_b;
        sub_q <= dec_sub;
        br_q  <= dec_br;
`ifdef ALU_ILLEGAL_TRAP_EN
        ill_q <= dec_ill;
`endif
      end
      if (state_q == StIssue) begin
        result_q <= result_d;
        zero_q   <= zero_d;
        taken_q  <= taken_d;
`ifdef ALU_ILLEGAL_TRAP_EN
        illegal_q <= ill_q;
`endif
      end
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign taken  = taken_q;
`ifdef ALU_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: bench-side ALU, phase-level reference model, per-cycle compare.
// Build with or without ALU_ILLEGAL_TRAP_EN to match the RTL.
module tb_alu_issue_unit;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [N-1:0]  rs1_val, rs2_val, imm;
  logic [N-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]    alu_ctrl;
  logic          alu_zero;
  logic          out_valid, out_ready;
  logic [N-1:0]  result;
  logic          zero, taken;
  logic          ill_out;

  int n_pass  = 0;
  int n_total = 0;

  alu_issue_unit #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .imm        (imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
`ifdef ALU_ILLEGAL_TRAP_EN
    .illegal    (ill_out),
`endif
    .taken      (taken)
  );

`ifndef ALU_ILLEGAL_TRAP_EN
  assign ill_out = 1'b0;
`endif

  always #5 clk = ~clk;

  // External adder/subtractor.
  assign alu_result = (alu_ctrl == 2'b01) ? alu_a - alu_b : alu_a + alu_b;
  assign alu_zero   = (alu_result == '0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: 0 = idle, 1 = issuing, 2 = result presented.
  int          m_phase = 0;
  bit          m_started = 0, m_fresh = 0;
  logic [31:0] m_a, m_b, m_res;
  logic [1:0]  m_ctrl;
  logic        m_zero, m_taken, m_ill;

  function automatic void model_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] im);
    bit r_type, i_type, beq, bne, known;
    r_type = (opc == 7'b0110011) && (f3 == 3'd0);
    i_type = ((opc == 7'b0010011) && (f3 == 3'd0)) || opc == 7'b0000011 || opc == 7'b0100011;
    beq    = (opc == 7'b1100011) && (f3 == 3'd0);
    bne    = (opc == 7'b1100011) && (f3 == 3'd1);
    known  = r_type || i_type || beq || bne;
    m_a    = r1;
    m_b    = i_type ? im : r2;
    m_ctrl = ((r_type && f7) || beq || bne) ? 2'b01 : 2'b00;
    m_res  = (m_ctrl == 2'b01) ? r1 - m_b : r1 + m_b;
    m_zero = (m_res == 32'd0);
    m_taken = beq ? m_zero : (bne ? !m_zero : 1'b0);
    m_ill  = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
    if (!known) begin
      m_res   = 32'd0;
      m_taken = 1'b0;
      m_ill   = 1'b1;
    end
`else
    if (known) m_ill = 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_started = 1; m_fresh = 1;
      m_res = 0; m_zero = 0; m_taken = 0; m_ill = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             model_op(opcode, funct3, funct7b5, rs1_val, rs2_val, imm);
             m_phase = 1; m_fresh = 0;
           end
        1: m_phase = 2;
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 1) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_ctrl", alu_ctrl, m_ctrl);
      end else begin
        chk("alu_a_idle", alu_a, 0);
        chk("alu_b_idle", alu_b, 0);
        chk("alu_ctrl_idle", alu_ctrl, 0);
      end
      if (m_phase == 2 || m_fresh) begin
        chk("result", result, m_res);
        if (!m_ill) chk("zero", zero, m_zero);
        chk("taken", taken, m_taken);
        chk("illegal", ill_out, m_ill);
      end
    end
  end

  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                        input int stall, input logic [31:0] e_res, input logic e_zero,
                        input logic e_taken, input logic [1:0] e_ctrl, input logic e_ill);
    int n;
    @(posedge clk); #1;
    opcode = opc; funct3 = f3; funct7b5 = f7; rs1_val = r1; rs2_val = r2; imm = im;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("issue_no_valid", out_valid, 0);
    chk("issue_ctrl_lit", alu_ctrl, e_ctrl);
    // Junk while busy must be ignored.
    opcode = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
    rs1_val = $urandom; rs2_val = $urandom; imm = $urandom;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 8);
    chk("latency", n, 1);
    chk("result_lit", result, e_res);
    if (!e_ill) chk("zero_lit", zero, e_zero);
    chk("taken_lit", taken, e_taken);
    chk("illegal_lit", ill_out, e_ill);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, e_res);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("back_idle", in_ready, 1);
    chk("back_no_valid", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0; rs1_val = '0; rs2_val = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);

    run_op(7'b0110011, 3'b000, 1'b0, 5, 7, 0, 0, 12, 0, 0, 2'b00, 0);
    run_op(7'b0110011, 3'b000, 1'b1, 5, 5, 0, 0, 0, 1, 0, 2'b01, 0);
    run_op(7'b1100011, 3'b000, 1'b0, 3, 3, 0, 0, 0, 1, 1, 2'b01, 0);
    run_op(7'b1100011, 3'b001, 1'b0, 3, 3, 0, 0, 0, 1, 0, 2'b01, 0);
    run_op(7'b1100011, 3'b001, 1'b0, 3, 4, 0, 0, 32'hFFFF_FFFF, 0, 1, 2'b01, 0);
    run_op(7'b0010011, 3'b000, 1'b0, 10, 99, 32'hFFFF_FFFD, 0, 7, 0, 0, 2'b00, 0);
    run_op(7'b0000011, 3'b010, 1'b0, 32'h1000, 9, 4, 0, 32'h1004, 0, 0, 2'b00, 0);
    run_op(7'b0100011, 3'b010, 1'b1, 32'hFFFF_FFFF, 9, 1, 0, 0, 1, 0, 2'b00, 0);
    run_op(7'b0110011, 3'b000, 1'b0, 100, 23, 0, 4, 123, 0, 0, 2'b00, 0);
`ifdef ALU_ILLEGAL_TRAP_EN
    run_op(7'b1110011, 3'b000, 1'b0, 2, 3, 0, 0, 0, 0, 0, 2'b00, 1);
    run_op(7'b0110011, 3'b111, 1'b1, 6, 1, 0, 0, 0, 0, 0, 2'b00, 1);
`else
    run_op(7'b1110011, 3'b000, 1'b0, 2, 3, 0, 0, 5, 0, 0, 2'b00, 0);
    run_op(7'b0110011, 3'b111, 1'b1, 6, 1, 0, 0, 7, 0, 0, 2'b00, 0);
`endif

    // Reset while issuing: op is dropped.
    @(posedge clk); #1;
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; rs1_val = 1; rs2_val = 1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_quiet", out_valid, 0);
    end
    run_op(7'b0110011, 3'b000, 1'b0, 40, 2, 0, 1, 42, 0, 0, 2'b00, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
